// File: rtl/fpga_robots_game_ps2rx.sv
`default_nettype none
// ============================================================================
// Module   : fpga_robots_game_ps2rx
// Brief    : PS/2 keyboard receiver: pin conditioning, frame deframing, FWFT
//            scan-code FIFO with valid/ready and clock-line inhibit.
// Revision : 1.0 - initial release
// ============================================================================
module fpga_robots_game_ps2rx #(
    parameter int FILT    = 8,
    parameter int TIMEOUT = 334,
    parameter int DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sixus,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_inhibit,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       err_parity,
    output logic       err_frame,
    output logic       err_timeout,
    output logic       err_overflow
);

    localparam int              c_AW     = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL   = (c_AW+1)'(DEPTH);
    localparam logic [7:0]      c_FILT_M = 8'(FILT - 1);
    localparam logic [8:0]      c_TO_M   = 9'(TIMEOUT - 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_DATA   = 2'd1;
    localparam logic [1:0] c_PARITY = 2'd2;
    localparam logic [1:0] c_STOP   = 2'd3;

    // ---------------- input conditioning ----------------
    logic       r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic [7:0] r_filt_cnt;
    logic       r_clk_f, r_clk_f_d;
    logic       r_inhibit;
    logic       w_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk_in;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_dat_in;
            r_dat_s2 <= r_dat_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_filt_cnt <= 8'd0;
            r_clk_f    <= 1'b1;
            r_clk_f_d  <= 1'b1;
        end else begin
            r_clk_f_d <= r_clk_f;
            if (r_clk_s2 != r_clk_f) begin
                if (r_filt_cnt == c_FILT_M) begin
                    r_clk_f    <= r_clk_s2;
                    r_filt_cnt <= 8'd0;
                end else begin
                    r_filt_cnt <= r_filt_cnt + 8'd1;
                end
            end else begin
                r_filt_cnt <= 8'd0;
            end
        end
    end

    // Falls seen while the device is inhibited are our own pull-down, not data.
    assign w_fall = r_clk_f_d & ~r_clk_f & ~r_inhibit;

    // ---------------- frame FSM ----------------
    logic [1:0] r_state, w_state_nx;
    logic [2:0] r_bit_cnt, w_bit_cnt_nx;
    logic [7:0] r_shift, w_shift_nx;
    logic       r_par, w_par_nx;
    logic [8:0] r_to_cnt, w_to_cnt_nx;
    logic       w_push, w_perr, w_ferr, w_terr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
            r_par     <= 1'b0;
            r_to_cnt  <= 9'd0;
        end else begin
            r_state   <= w_state_nx;
            r_bit_cnt <= w_bit_cnt_nx;
            r_shift   <= w_shift_nx;
            r_par     <= w_par_nx;
            r_to_cnt  <= w_to_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_bit_cnt_nx = r_bit_cnt;
        w_shift_nx   = r_shift;
        w_par_nx     = r_par;
        w_to_cnt_nx  = r_to_cnt;
        w_push       = 1'b0;
        w_perr       = 1'b0;
        w_ferr       = 1'b0;
        w_terr       = 1'b0;

        if (r_state == c_IDLE || w_fall)
            w_to_cnt_nx = 9'd0;
        else if (sixus)
            w_to_cnt_nx = r_to_cnt + 9'd1;

        case (r_state)
            c_IDLE: begin
                if (w_fall && !r_dat_s2) begin
                    w_state_nx   = c_DATA;
                    w_bit_cnt_nx = 3'd0;
                end
            end
            c_DATA: begin
                if (w_fall) begin
                    w_shift_nx   = {r_dat_s2, r_shift[7:1]};
                    w_bit_cnt_nx = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7)
                        w_state_nx = c_PARITY;
                end
            end
            c_PARITY: begin
                if (w_fall) begin
                    w_par_nx   = r_dat_s2;
                    w_state_nx = c_STOP;
                end
            end
            c_STOP: begin
                if (w_fall) begin
                    w_state_nx = c_IDLE;
                    if (!r_dat_s2)
                        w_ferr = 1'b1;
                    else if (^{r_shift, r_par} == 1'b0)
                        w_perr = 1'b1;
                    else
                        w_push = 1'b1;
                end
            end
            default: w_state_nx = c_IDLE;
        endcase

        // A fall in the same cycle keeps the frame alive.
        if (r_state != c_IDLE && !w_fall && sixus && r_to_cnt == c_TO_M) begin
            w_state_nx  = c_IDLE;
            w_to_cnt_nx = 9'd0;
            w_terr      = 1'b1;
        end
    end

    // ---------------- FWFT FIFO ----------------
    logic [7:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wptr, r_rptr;
    logic [c_AW:0]   r_count;
    logic            w_pop, w_push_ok, w_ovf;

    assign rx_valid  = (r_count != '0);
    assign w_pop     = rx_valid & rx_ready;
    assign w_push_ok = w_push & ((r_count < c_FULL) | w_pop);
    assign w_ovf     = w_push & ~w_push_ok;
    assign rx_data   = rx_valid ? r_mem[r_rptr] : 8'd0;

    always_ff @(posedge clk) begin
        if (!rst && w_push_ok)
            r_mem[r_wptr] <= r_shift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok)
                r_wptr <= r_wptr + c_AW'(1);
            if (w_pop)
                r_rptr <= r_rptr + c_AW'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------- inhibit and error pulses ----------------
    // Only assert between frames, and not while the consumer is draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inhibit    <= 1'b0;
            err_parity   <= 1'b0;
            err_frame    <= 1'b0;
            err_timeout  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            r_inhibit    <= (r_count == c_FULL) &&
                            (r_inhibit || (r_state == c_IDLE && !w_pop));
            err_parity   <= w_perr;
            err_frame    <= w_ferr;
            err_timeout  <= w_terr;
            err_overflow <= w_ovf;
        end
    end

    assign ps2_clk_inhibit = r_inhibit;

endmodule
`default_nettype wire

// File: tb/tb_fpga_robots_game_ps2rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpga_robots_game_ps2rx
// Brief    : Self-checking bench for the PS/2 receiver with a PS/2 device model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpga_robots_game_ps2rx;

    localparam int c_DEPTH = 4;
    localparam int c_HALF  = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sixus = 1'b0;
    logic       ps2c_drv = 1'b1;
    logic       ps2d = 1'b1;
    logic       ps2_clk_pin;
    logic       ps2_clk_inhibit;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       err_parity, err_frame, err_timeout, err_overflow;

    int vectors = 0;
    int miscompares = 0;
    int n_p = 0, n_f = 0, n_t = 0, n_o = 0, n_multi = 0;
    int s_p, s_f, s_t, s_o;

    // The clock line is open-collector: inhibit pulls it low over the device.
    assign ps2_clk_pin = ps2c_drv & ~ps2_clk_inhibit;

    fpga_robots_game_ps2rx #(.FILT(8), .TIMEOUT(334), .DEPTH(c_DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .sixus           (sixus),
        .ps2_clk_in      (ps2_clk_pin),
        .ps2_dat_in      (ps2d),
        .ps2_clk_inhibit (ps2_clk_inhibit),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .err_parity      (err_parity),
        .err_frame       (err_frame),
        .err_timeout     (err_timeout),
        .err_overflow    (err_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (3) @(negedge clk);
            sixus = 1'b1;
            @(negedge clk);
            sixus = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (err_parity)   n_p++;
        if (err_frame)    n_f++;
        if (err_timeout)  n_t++;
        if (err_overflow) n_o++;
        if (int'(err_parity) + int'(err_frame) + int'(err_timeout) + int'(err_overflow) > 1)
            n_multi++;
    end

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       exp_push;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t tbl[7];
    logic [7:0] mq[$];

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic snap();
        s_p = n_p; s_f = n_f; s_t = n_t; s_o = n_o;
    endtask

    task automatic check_errs(input string nm, input int ep, input int ef, input int et, input int eo);
        check({nm, " err_parity cycles"},   32'(n_p - s_p), 32'(ep));
        check({nm, " err_frame cycles"},    32'(n_f - s_f), 32'(ef));
        check({nm, " err_timeout cycles"},  32'(n_t - s_t), 32'(et));
        check({nm, " err_overflow cycles"}, 32'(n_o - s_o), 32'(eo));
    endtask

    // Device-side frame: start, 8 data LSB first, parity, stop; nbits < 11 truncates.
    task automatic send(input logic [7:0] d, input logic p, input logic s,
                        input int nbits, input int glitch_at);
        logic [10:0] fr;
        fr = {s, p, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2d = fr[i];
            if (i == glitch_at) begin
                wait_cyc(c_HALF / 2);
                ps2c_drv = 1'b0;
                wait_cyc(3);
                ps2c_drv = 1'b1;
                wait_cyc(c_HALF - c_HALF / 2 - 3);
            end else begin
                wait_cyc(c_HALF);
            end
            ps2c_drv = 1'b0;
            wait_cyc(c_HALF);
            ps2c_drv = 1'b1;
        end
        ps2d = 1'b1;
        wait_cyc(c_HALF);
    endtask

    task automatic good_parity(input logic [7:0] d, output logic p);
        p = ($countones(d) % 2 == 0);
    endtask

    task automatic pop_expect(input string nm, input logic [7:0] exp);
        check({nm, " rx_valid"}, 32'(rx_valid), 32'd1);
        check({nm, " rx_data"},  32'(rx_data),  32'(exp));
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        logic       p;
        logic [7:0] d;
        int         kind, npop;
        bit         ignored, exp_push, exp_perr, exp_ferr;

        tbl[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'h1C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{8'hF0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        wait_cyc(5);
        check("reset rx_valid", 32'(rx_valid), 32'd0);
        check("reset rx_data", 32'(rx_data), 32'd0);
        check("reset inhibit", 32'(ps2_clk_inhibit), 32'd0);
        check("reset err_*", 32'({err_parity, err_frame, err_timeout, err_overflow}), 32'd0);
        rst = 1'b0;
        wait_cyc(20);

        for (int i = 0; i < 7; i++) begin
            snap();
            send(tbl[i].data, tbl[i].par, tbl[i].stop, 11, -1);
            wait_cyc(10);
            check_errs($sformatf("tbl%0d", i), int'(tbl[i].exp_perr), int'(tbl[i].exp_ferr), 0, 0);
            if (tbl[i].exp_push) begin
                pop_expect($sformatf("tbl%0d", i), tbl[i].data);
                check($sformatf("tbl%0d empty after pop", i), 32'(rx_valid), 32'd0);
            end else begin
                check($sformatf("tbl%0d no byte", i), 32'(rx_valid), 32'd0);
            end
        end

        // Glitch on the clock line during the data phase must be rejected.
        snap();
        send(8'h5A, 1'b1, 1'b1, 11, 3);
        wait_cyc(10);
        check_errs("glitch", 0, 0, 0, 0);
        pop_expect("glitch", 8'h5A);

        // Partial frame then silence.
        snap();
        send(8'h29, 1'b0, 1'b1, 5, -1);
        wait_cyc(1500);
        check_errs("timeout", 0, 0, 1, 0);
        check("timeout no byte", 32'(rx_valid), 32'd0);
        snap();
        send(8'h29, 1'b0, 1'b1, 11, -1);
        wait_cyc(10);
        check_errs("after timeout", 0, 0, 0, 0);
        pop_expect("after timeout", 8'h29);

        // Fill the FIFO, then a fifth frame while inhibited.
        snap();
        for (int i = 1; i <= 4; i++) begin
            good_parity(8'(i), p);
            send(8'(i), p, 1'b1, 11, -1);
            wait_cyc(20);
        end
        check("full inhibit", 32'(ps2_clk_inhibit), 32'd1);
        check("full head", 32'(rx_data), 32'h01);
        send(8'h05, 1'b1, 1'b1, 11, -1);
        wait_cyc(20);
        check_errs("inhibited frame", 0, 0, 0, 0);
        check("still inhibit", 32'(ps2_clk_inhibit), 32'd1);
        pop_expect("drain1", 8'h01);
        @(negedge clk);
        check("inhibit drops", 32'(ps2_clk_inhibit), 32'd0);
        for (int i = 2; i <= 4; i++) pop_expect($sformatf("drain%0d", i), 8'(i));
        check("drained", 32'(rx_valid), 32'd0);
        wait_cyc(50);

        // Reset mid-frame with a byte already queued.
        snap();
        send(8'h33, 1'b1, 1'b1, 11, -1);
        send(8'h76, 1'b0, 1'b1, 4, -1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid rst rx_valid", 32'(rx_valid), 32'd0);
        check("mid rst rx_data", 32'(rx_data), 32'd0);
        check("mid rst inhibit", 32'(ps2_clk_inhibit), 32'd0);
        wait_cyc(30);
        send(8'h76, 1'b0, 1'b1, 11, -1);
        wait_cyc(10);
        check_errs("reset frame", 0, 0, 0, 0);
        pop_expect("after rst", 8'h76);

        // Randomised frames against a queue model of the receiver.
        for (int it = 0; it < 12; it++) begin
            d    = 8'($urandom);
            kind = $urandom_range(0, 5);
            good_parity(d, p);
            if (kind == 4) p = ~p;
            ignored  = (mq.size() == c_DEPTH);
            exp_ferr = !ignored && (kind == 5);
            exp_perr = !ignored && (kind != 5) && ($countones({d, p}) % 2 == 0);
            exp_push = !ignored && !exp_ferr && !exp_perr;
            snap();
            send(d, p, (kind != 5), 11, -1);
            wait_cyc(10);
            if (exp_push) mq.push_back(d);
            check_errs($sformatf("rnd%0d", it), int'(exp_perr), int'(exp_ferr), 0, 0);
            check($sformatf("rnd%0d valid", it), 32'(rx_valid), 32'(mq.size() != 0));
            npop = $urandom_range(0, 2);
            for (int k = 0; k < npop && mq.size() > 0; k++)
                pop_expect($sformatf("rnd%0d pop%0d", it, k), mq.pop_front());
            wait_cyc(40);
        end
        while (mq.size() > 0) pop_expect("rnd drain", mq.pop_front());
        check("rnd empty", 32'(rx_valid), 32'd0);
        check("error exclusivity", 32'(n_multi), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fpga_robots_game_ps2rx.md
# fpga_robots_game_ps2rx

PS/2 keyboard receiver. It sits directly downstream of the PS/2 A port pins and upstream of the game-play key decoder. It synchronises and filters the device clock and data lines and deframes 11-bit PS/2 frames. Good scan-code bytes go into a small first-word-fall-through FIFO with a valid/ready output. When the FIFO is full, it inhibits the device by requesting the top level to pull the clock line low.

## Interface
- FILT, 8: clk cycles the synchronised PS/2 clock must be stable before the filtered clock follows it (2..255).
- TIMEOUT, 334: `sixus` pulses with no filtered clock edge before an in-progress frame is aborted (≈2 ms; 1..511).
- DEPTH, 4: FIFO entries; power of two, 2..16.
- clk  in  1  ~65 MHz system clock.
- rst  in  1  reset, synchronous, active-high.
- sixus  in  1  one-cycle pulse every ~6 µs from the clock block.
- ps2_clk_in  in  1  raw PS/2 clock pin level (asynchronous).
- ps2_dat_in  in  1  raw PS/2 data pin level (asynchronous).
- ps2_clk_inhibit  out  1  1 = top level drives the PS/2 clock pin low; 0 = release to high-Z.
- rx_data  out  8  head-of-FIFO byte; valid only while rx_valid = 1.
- rx_valid  out  1  FIFO non-empty.
- rx_ready  in  1  consumer accepts the head byte this cycle.
- err_parity  out  1  one-cycle pulse: frame dropped, odd parity failed.
- err_frame  out  1  one-cycle pulse: frame dropped, stop bit was 0.
- err_timeout  out  1  one-cycle pulse: partial frame aborted.
- err_overflow  out  1  one-cycle pulse: good byte dropped, FIFO full.

## Operation
- Input conditioning:
  - Two-flop synchronisers on both pins; reset value 1.
  - Filter counter: when the synchronised clock differs from the filtered clock for FILT consecutive cycles, the filtered clock takes the new value. Any agreement resets the counter.
  - Filtered-clock reset value is 1.
  - A fall event is the cycle in which the filtered clock goes 1→0. Synchronised data is sampled in that cycle.
- Frame FSM states:
  - IDLE: on a fall event with data = 0 (start bit), go to DATA and clear the bit counter. A fall with data = 1 stays in IDLE with no error.
  - DATA: on each fall, shift data into the byte LSB first. After the 8th bit, go to PARITY.
  - PARITY: on a fall, store the bit and go to STOP.
  - STOP: on a fall, evaluate the frame:
    - stop bit = 0 → err_frame.
    - otherwise, XOR of the 8 data bits and the parity bit = 0 → err_parity.
    - otherwise push the byte.
    - Return to IDLE in all cases.
- Timeout:
  - The counter clears on every fall event and while in IDLE.
  - It increments on each `sixus` pulse while the FSM is not in IDLE.
  - Reaching TIMEOUT forces IDLE and pulses err_timeout. The partial byte is discarded.
- FIFO:
  - First-word fall-through; count width log2(DEPTH)+1.
  - A pop occurs when rx_valid && rx_ready.
  - A push is accepted when count < DEPTH, or when a pop occurs in the same cycle. Otherwise the byte is dropped and err_overflow pulses.
  - Pointers wrap modulo DEPTH.
- Inhibit:
  - ps2_clk_inhibit rises only when count = DEPTH and the FSM is in IDLE. A frame in progress is never cut.
  - It falls the cycle after count < DEPTH.
  - While inhibit = 1, fall events are ignored and the FSM is held in IDLE.
- Reset:
  - FSM goes to IDLE; FIFO is emptied; all counters clear.
  - rx_valid = 0, rx_data = 0, ps2_clk_inhibit = 0, all err_* = 0.
  - Reset mid-frame discards the partial frame with no error pulse.

## Timing
- Pin to filtered clock: 2 synchroniser cycles + FILT cycles.
- Stop-bit fall event in cycle N: the push or error pulse is registered at the end of N.
  - err_* is high during cycle N+1 only.
  - rx_valid is 1 from N+1 when the FIFO was empty.
- Pop in cycle M: the next byte is on rx_data in M+1; rx_valid = 0 in M+1 if the FIFO became empty.
- Simultaneous push and pop with the FIFO full: both take effect and count is unchanged. Inhibit does not rise.
- Simultaneous push and pop with count = 1: rx_valid stays 1 and rx_data shows the new byte in the next cycle.
- Error pulses are mutually exclusive within a cycle.
- No combinational path from rx_ready to any output.

## Test plan
- Frame 0x1C with parity 0 and stop 1, at 12.5 kHz PS/2 clock -> rx_valid = 1 with rx_data = 0x1C; rx_ready = 1 for one cycle -> rx_valid = 0; no err_*.
- Same frame with parity 1 -> err_parity pulses exactly one cycle; rx_valid stays 0. Then 0xF0 with correct parity -> rx_data = 0xF0.
- A 3-cycle low glitch on ps2_clk_in (FILT = 8) during DATA -> no bit is shifted; the subsequent full frame 0x5A decodes correctly.
- Send start bit plus 4 data bits, then hold the clock high for >335 sixus pulses -> err_timeout pulses once; the next frame 0x29 decodes correctly.
- rx_ready held 0; send 5 frames (0x01..0x05) with DEPTH = 4:
  - ps2_clk_inhibit = 1 after the 4th frame.
  - The 5th frame is ignored while inhibited.
  - Raise rx_ready -> bytes 0x01..0x04 come out in order and inhibit drops after the first pop.
- Assert rst for one cycle mid-frame, after 3 data bits -> all outputs return to reset values, with no err_* pulse. The following frame 0x76 decodes correctly.
